// File: rtl/ms_timer_pkg.sv
// Shared types and constants for the millisecond timer scheduler.
package ms_timer_pkg;

  localparam int unsigned DEF_CLK_HZ  = 50_000_000;
  localparam int unsigned DEF_TICK_HZ = 1000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Clock cycles per tick; CLK_HZ must be an integer multiple of TICK_HZ.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick enable every DIV clocks.
module tick_prescaler #(
  parameter  int unsigned DIV = 10,
  localparam int unsigned PW  = $clog2(DIV)
) (
  input  logic          cin,
  input  logic          rst_n,
  input  logic          enable,
  output logic          tick_en,
  output logic [PW-1:0] presc
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_d, presc_q;

  // NOTE: combinational blocks assign a default to every output first so no latch is inferred.
  always_comb begin
    presc_d = presc_q;
    if (enable) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  assign tick_en = enable && (presc_q == LAST);
  assign presc   = presc_q;

endmodule

// File: rtl/ms_timer_scheduler.sv
// Shared 1 ms tick plus NCH one-shot/periodic countdown channels with load and cancel.
module ms_timer_scheduler
  import ms_timer_pkg::*;
#(
  parameter  int unsigned CLK_HZ  = DEF_CLK_HZ,
  parameter  int unsigned TICK_HZ = DEF_TICK_HZ,
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned CH_W    = $clog2(NCH)
) (
  input  logic             cin,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_ms,
  input  logic             load_periodic,
  input  logic [NCH-1:0]   cancel,
  output logic [NCH-1:0]   active,
  output logic [NCH-1:0]   expired,
  output logic             tick,
  output logic [31:0]      ms_count
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = $clog2(DIV);

  logic          tick_en;
  logic [PW-1:0] presc;
  logic          unused_presc;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .cin     (cin),
    .rst_n   (rst_n),
    .enable  (enable),
    .tick_en (tick_en),
    .presc   (presc)
  );

  // presc is kept visible for debug; nothing downstream consumes it.
  assign unused_presc = ^presc;

  // Holding off loads during tick_en keeps a load and a decrement from ever colliding.
  assign load_ready = !tick_en;

  logic             load_fire;
  logic [CNT_W-1:0] load_val;

  assign load_fire = load_valid && load_ready;
  assign load_val  = (load_ms == '0) ? CNT_W'(1) : load_ms;

  logic        tick_d, tick_q;
  logic [31:0] ms_count_d, ms_count_q;

  always_comb begin
    tick_d     = tick_en;
    ms_count_d = ms_count_q + (tick_en ? 32'd1 : 32'd0);
  end

  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= 1'b0;
      ms_count_q <= '0;
    end else begin
      tick_q     <= tick_d;
      ms_count_q <= ms_count_d;
    end
  end

  assign tick     = tick_q;
  assign ms_count = ms_count_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    ch_state_e        state_d, state_q;
    logic [CNT_W-1:0] rem_d, rem_q, reload_d, reload_q;
    logic             per_d, per_q, exp_d, exp_q;

    always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      reload_d = reload_q;
      per_d    = per_q;
      exp_d    = 1'b0;
      if (load_fire && (load_ch == IDX)) begin
        state_d  = CH_RUN;
        rem_d    = load_val;
        reload_d = load_val;
        per_d    = load_periodic;
      end else if (cancel[i]) begin
        state_d = CH_IDLE;
      end else if (tick_en && (state_q == CH_RUN)) begin
        if (rem_q == CNT_W'(1)) begin
          exp_d = 1'b1;
          if (per_q) rem_d   = reload_q;
          else       state_d = CH_IDLE;
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
    end

    // NOTE: rem/reload are cleared on reset too so the channel never starts from X in simulation.
    always_ff @(posedge cin or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= CH_IDLE;
        rem_q    <= '0;
        reload_q <= '0;
        per_q    <= 1'b0;
        exp_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        rem_q    <= rem_d;
        reload_q <= reload_d;
        per_q    <= per_d;
        exp_q    <= exp_d;
      end
    end

    assign active[i]  = (state_q == CH_RUN);
    assign expired[i] = exp_q;
  end

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Directed scoreboard bench: stimulus pushes expected tick/expiry events, a monitor pops them.
module tb_ms_timer_scheduler;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  logic             cin = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b1;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [1:0]       load_ch = '0;
  logic [CNT_W-1:0] load_ms = '0;
  logic             load_periodic = 1'b0;
  logic [NCH-1:0]   cancel = '0;
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   expired;
  logic             tick;
  logic [31:0]      ms_count;

  int unsigned cyc;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    int unsigned    cyc;
    logic [NCH-1:0] exp;
    logic [31:0]    ms;
  } ev_t;

  ev_t sb[$];

  ms_timer_scheduler #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .NCH    (NCH),
    .CNT_W  (CNT_W)
  ) dut (
    .cin           (cin),
    .rst_n         (rst_n),
    .enable        (enable),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_ch       (load_ch),
    .load_ms       (load_ms),
    .load_periodic (load_periodic),
    .cancel        (cancel),
    .active        (active),
    .expired       (expired),
    .tick          (tick),
    .ms_count      (ms_count)
  );

  always #5 cin = ~cin;

  // Cycle stamp: edge n after reset release reads n.
  always @(posedge cin or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [NCH-1:0] e, input logic [31:0] m);
    ev_t ev;
    ev.cyc = c;
    ev.exp = e;
    ev.ms  = m;
    sb.push_back(ev);
  endtask

  task automatic step();
    @(posedge cin);
    #1;
  endtask

  task automatic goto(input int unsigned n);
    for (int g = 0; g < 500 && cyc != n; g++) step();
    if (cyc != n) begin
      n_vec++;
      n_bad++;
      $display("FAIL goto: got cyc %0d expected %0d", cyc, n);
    end
  endtask

  task automatic load(input logic [1:0] ch, input logic [CNT_W-1:0] ms, input logic per);
    load_ch       = ch;
    load_ms       = ms;
    load_periodic = per;
    load_valid    = 1'b1;
  endtask

  // Monitor: any cycle with tick or expiry must match the next expected event.
  always @(negedge cin) begin : monitor
    ev_t e;
    if (rst_n && (tick || expired != '0)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_event: got tick=%b expired=%b at cyc %0d expected none",
                 tick, expired, cyc);
      end else begin
        e = sb.pop_front();
        check("ev_tick", tick, 1);
        check("ev_cyc", cyc, e.cyc);
        check("ev_expired", expired, e.exp);
        check("ev_ms_count", ms_count, e.ms);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release with enable high: ticks every 10 cycles.
    push(10, 4'b0000, 1);
    push(20, 4'b0000, 2);
    push(30, 4'b0000, 3);
    repeat (2) @(posedge cin);
    #1;
    check("rst_tick", tick, 0);
    check("rst_expired", expired, 0);
    check("rst_active", active, 0);
    check("rst_ms_count", ms_count, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_presc", dut.presc, 0);
    rst_n = 1'b1;

    // One-shot ch0, 3 ms, accepted with presc=0 at edge 31.
    goto(30);
    push(40, 4'b0000, 4);
    push(50, 4'b0000, 5);
    push(60, 4'b0001, 6);
    load(2'd0, 16'd3, 1'b0);
    step();
    load_valid = 1'b0;
    check("oneshot_active_rise", active, 4'b0001);
    goto(59);
    check("oneshot_active_hold", active, 4'b0001);
    step();
    check("oneshot_active_fall", active, 4'b0000);

    // Periodic ch1, 2 ms, accepted at edge 61; cancelled in the tick_en cycle before 140.
    push(70,  4'b0000, 7);
    push(80,  4'b0010, 8);
    push(90,  4'b0000, 9);
    push(100, 4'b0010, 10);
    push(110, 4'b0000, 11);
    push(120, 4'b0010, 12);
    push(130, 4'b0000, 13);
    push(140, 4'b0000, 14);
    load(2'd1, 16'd2, 1'b1);
    step();
    load_valid = 1'b0;
    check("periodic_active_rise", active, 4'b0010);
    goto(121);
    check("periodic_active_hold", active, 4'b0010);
    goto(139);
    cancel = 4'b0010;
    step();
    cancel = '0;
    check("cancel_active_fall", active, 4'b0000);

    // Load held across tick_en, with load_ms=0 on ch2.
    goto(149);
    push(150, 4'b0000, 15);
    push(160, 4'b0100, 16);
    load(2'd2, 16'd0, 1'b0);
    check("ready_low_on_tick", load_ready, 0);
    step();
    check("ready_high_after_tick", load_ready, 1);
    check("no_accept_on_tick", active, 4'b0000);
    step();
    load_valid = 1'b0;
    check("accept_after_tick", active, 4'b0100);

    // Freeze: ch3 3 ms one-shot, enable low for 25 edges (166..190).
    goto(160);
    check("zero_load_fall", active, 4'b0000);
    push(195, 4'b0000, 17);
    push(205, 4'b0000, 18);
    push(215, 4'b1000, 19);
    load(2'd3, 16'd3, 1'b0);
    step();
    load_valid = 1'b0;
    goto(165);
    check("freeze_presc_before", dut.presc, 5);
    enable = 1'b0;
    goto(190);
    check("freeze_presc_after", dut.presc, 5);
    check("freeze_ms_count", ms_count, 16);
    check("freeze_ready", load_ready, 1);
    check("freeze_active", active, 4'b1000);
    enable = 1'b1;
    goto(214);
    check("delayed_active_hold", active, 4'b1000);
    step();
    check("delayed_active_fall", active, 4'b0000);

    // Mid-run reset with a periodic ch0 running.
    push(225, 4'b0000, 20);
    load(2'd0, 16'd5, 1'b1);
    step();
    load_valid = 1'b0;
    check("pre_reset_active", active, 4'b0001);
    goto(228);
    rst_n = 1'b0;
    #1;
    check("midrst_active", active, 0);
    check("midrst_ms_count", ms_count, 0);
    check("midrst_tick", tick, 0);
    check("midrst_expired", expired, 0);
    check("midrst_presc", dut.presc, 0);
    check("midrst_load_ready", load_ready, 1);
    push(10, 4'b0000, 1);
    push(20, 4'b0000, 2);
    repeat (3) step();
    rst_n = 1'b1;
    goto(25);
    check("post_reset_active", active, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
